// File: rtl/bm_dot_accumulator.sv
// Saturating dot-product accumulator behind the 4x4 Booth multiplier.
// Sums LEN signed products and offers the result on a valid/ready port.
module bm_dot_accumulator #(
  parameter int unsigned PROD_W = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned LEN    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic [PROD_W-1:0]          prod_in,
  input  logic                       prod_valid,
  output logic                       prod_ready,
  output logic [ACC_W-1:0]           acc_out,
  output logic                       acc_valid,
  input  logic                       acc_ready,
  output logic                       ovf,
  output logic [$clog2(LEN+1)-1:0]   cnt
);

  localparam int unsigned CNT_W = $clog2(LEN + 1);
  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic signed [SUM_W-1:0] sum;
  logic [ACC_W-1:0]        sat_val;
  logic                    sat_hit;
  logic                    accept;

  // Ready depends on state only; forced low while reset is held.
  assign prod_ready = rst_n & (state_q != HOLD);
  assign accept     = prod_valid & prod_ready;

  // One guard bit catches overflow; clamp toward the sign of the true sum.
  always_comb begin
    sum     = SUM_W'($signed(acc_q)) + SUM_W'($signed(prod_in));
    sat_hit = sum[SUM_W-1] ^ sum[SUM_W-2];
    sat_val = sum[ACC_W-1:0];
    if (sat_hit) begin
      sat_val = sum[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                             : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d = ACC_W'($signed(prod_in));
            cnt_d = CNT_W'(1);
            ovf_d = 1'b0;
            if (LEN == 1) begin
              state_d = HOLD;
              valid_d = 1'b1;
            end else begin
              state_d = ACC;
            end
          end
        end
        ACC: begin
          if (accept) begin
            acc_d = sat_val;
            ovf_d = ovf_q | sat_hit;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(LEN)) begin
              state_d = HOLD;
              valid_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (acc_ready) begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc_out   = acc_q;
  assign acc_valid = valid_q;
  assign ovf       = ovf_q;
  assign cnt       = cnt_q;

endmodule

// File: tb/tb_bm_dot_accumulator.sv
// Scoreboard bench for bm_dot_accumulator: default, narrow-accumulator
// and single-product instances driven side by side.
module tb_bm_dot_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int acc;
    bit ovf;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_s[$];
  exp_t sb_l[$];

  // Default instance
  logic        a_clr, a_pv, a_pr, a_av, a_ar, a_ovf;
  logic [7:0]  a_pin;
  logic [15:0] a_acc;
  logic [2:0]  a_cnt;
  // ACC_W = 8 instance
  logic        s_clr, s_pv, s_pr, s_av, s_ar, s_ovf;
  logic [7:0]  s_pin;
  logic [7:0]  s_acc;
  logic [2:0]  s_cnt;
  // LEN = 1 instance
  logic        l_clr, l_pv, l_pr, l_av, l_ar, l_ovf;
  logic [7:0]  l_pin;
  logic [15:0] l_acc;
  logic [0:0]  l_cnt;

  bm_dot_accumulator u_dut (
    .clk(clk), .rst_n(rst_n), .clr(a_clr), .prod_in(a_pin), .prod_valid(a_pv),
    .prod_ready(a_pr), .acc_out(a_acc), .acc_valid(a_av), .acc_ready(a_ar),
    .ovf(a_ovf), .cnt(a_cnt)
  );

  bm_dot_accumulator #(.PROD_W(8), .ACC_W(8), .LEN(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .clr(s_clr), .prod_in(s_pin), .prod_valid(s_pv),
    .prod_ready(s_pr), .acc_out(s_acc), .acc_valid(s_av), .acc_ready(s_ar),
    .ovf(s_ovf), .cnt(s_cnt)
  );

  bm_dot_accumulator #(.PROD_W(8), .ACC_W(16), .LEN(1)) u_len1 (
    .clk(clk), .rst_n(rst_n), .clr(l_clr), .prod_in(l_pin), .prod_valid(l_pv),
    .prod_ready(l_pr), .acc_out(l_acc), .acc_valid(l_av), .acc_ready(l_ar),
    .ovf(l_ovf), .cnt(l_cnt)
  );

  // Reference: running sum clamped after every add, sticky overflow flag.
  function automatic exp_t model4(input int p0, input int p1, input int p2,
                                  input int p3, input int accw);
    exp_t e;
    int mx, mn, p;
    mx = (1 << (accw - 1)) - 1;
    mn = -(1 << (accw - 1));
    e.acc = p0;
    e.ovf = 1'b0;
    for (int i = 1; i < 4; i++) begin
      p = (i == 1) ? p1 : (i == 2) ? p2 : p3;
      e.acc += p;
      if (e.acc > mx) begin
        e.acc = mx;
        e.ovf = 1'b1;
      end else if (e.acc < mn) begin
        e.acc = mn;
        e.ovf = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int p);
    a_pv  = 1'b1;
    a_pin = 8'(p);
    step();
    a_pv  = 1'b0;
    a_pin = 8'($urandom);
  endtask

  task automatic send_s(input int p);
    s_pv  = 1'b1;
    s_pin = 8'(p);
    step();
    s_pv  = 1'b0;
    s_pin = 8'($urandom);
  endtask

  task automatic test_reset();
    n_checks++;
    if (a_pr !== 1'b0 || s_pr !== 1'b0 || l_pr !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_prod_ready: got %b%b%b expected 000", a_pr, s_pr, l_pr);
    end
    n_checks++;
    if (a_acc !== 16'd0 || a_av !== 1'b0 || a_ovf !== 1'b0 || a_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: acc=%0d valid=%b ovf=%b cnt=%0d expected all 0",
               a_acc, a_av, a_ovf, a_cnt);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    sb_a.delete();
    sb_a.push_back(model4(21, -21, 21, 30, 16));
    a_ar = 1'b1;
    send_a(21); send_a(-21); send_a(21); send_a(30);
    n_checks++;
    if (a_av !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: acc_valid=%b expected 1", a_av);
    end
    e = sb_a.pop_front();
    n_checks++;
    if (int'($signed(a_acc)) !== e.acc || a_ovf !== e.ovf) begin
      n_fail++;
      $display("FAIL basic_result: acc=%0d ovf=%b expected %0d %b",
               $signed(a_acc), a_ovf, e.acc, e.ovf);
    end
    n_checks++;
    if (a_cnt !== 3'd4 || a_pr !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: cnt=%0d prod_ready=%b expected 4 0", a_cnt, a_pr);
    end
    step();
    n_checks++;
    if (a_av !== 1'b0 || a_cnt !== 3'd0 || a_pr !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_one_cycle: valid=%b cnt=%0d ready=%b expected 0 0 1",
               a_av, a_cnt, a_pr);
    end
  endtask

  task automatic test_gaps();
    exp_t e;
    int v[4];
    v = '{21, -21, 21, 30};
    sb_a.delete();
    sb_a.push_back(model4(21, -21, 21, 30, 16));
    a_ar = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_a(v[i]);
      if (i < 3) repeat ($urandom_range(1, 3)) step();
    end
    e = sb_a.pop_front();
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (a_av !== 1'b1 || int'($signed(a_acc)) !== e.acc || a_pr !== 1'b0) begin
        n_fail++;
        $display("FAIL gaps_hold[%0d]: valid=%b acc=%0d ready=%b expected 1 %0d 0",
                 k, a_av, $signed(a_acc), a_pr, e.acc);
      end
      a_pin = 8'($urandom);
      step();
    end
    a_ar = 1'b1;
    step();
    n_checks++;
    if (a_av !== 1'b0 || a_pr !== 1'b1 || a_cnt !== 3'd0 || int'($signed(a_acc)) !== e.acc) begin
      n_fail++;
      $display("FAIL gaps_release: valid=%b ready=%b cnt=%0d acc=%0d expected 0 1 0 %0d",
               a_av, a_pr, a_cnt, $signed(a_acc), e.acc);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int v[8];
    int idx, cyc, nres;
    bit acc_ok;
    v = '{1, 2, 3, 4, 5, 6, 7, 8};
    sb_a.delete();
    sb_a.push_back(model4(1, 2, 3, 4, 16));
    sb_a.push_back(model4(5, 6, 7, 8, 16));
    a_ar = 1'b1;
    idx = 0; cyc = 0; nres = 0;
    while (idx < 8 && cyc < 40) begin
      a_pv   = 1'b1;
      a_pin  = 8'(v[idx]);
      acc_ok = a_pr;
      step();
      cyc++;
      if (acc_ok) idx++;
      if (a_av) begin
        nres++;
        n_checks++;
        if (sb_a.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra_result: acc=%0d expected no result", $signed(a_acc));
        end else begin
          e = sb_a.pop_front();
          if (int'($signed(a_acc)) !== e.acc) begin
            n_fail++;
            $display("FAIL b2b_result: acc=%0d expected %0d", $signed(a_acc), e.acc);
          end
        end
      end
    end
    a_pv = 1'b0;
    n_checks++;
    if (nres != 2 || cyc != 9) begin
      n_fail++;
      $display("FAIL b2b_throughput: results=%0d cycles=%0d expected 2 9", nres, cyc);
    end
    step();
  endtask

  task automatic test_clr();
    exp_t e;
    sb_a.delete();
    a_ar = 1'b1;
    send_a(21); send_a(30);
    a_clr = 1'b1; a_pv = 1'b1; a_pin = 8'd99;
    step();
    a_clr = 1'b0; a_pv = 1'b0;
    n_checks++;
    if (a_cnt !== 3'd0 || a_acc !== 16'd0 || a_av !== 1'b0 || a_pr !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_abort: cnt=%0d acc=%0d valid=%b ready=%b expected 0 0 0 1",
               a_cnt, $signed(a_acc), a_av, a_pr);
    end
    sb_a.push_back(model4(5, 5, 5, 5, 16));
    repeat (4) send_a(5);
    e = sb_a.pop_front();
    n_checks++;
    if (a_av !== 1'b1 || int'($signed(a_acc)) !== e.acc) begin
      n_fail++;
      $display("FAIL clr_after: valid=%b acc=%0d expected 1 %0d", a_av, $signed(a_acc), e.acc);
    end
    step();
    a_ar = 1'b0;
    repeat (4) send_a(1);
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    n_checks++;
    if (a_av !== 1'b0 || a_acc !== 16'd0 || a_cnt !== 3'd0) begin
      n_fail++;
      $display("FAIL clr_hold_discard: valid=%b acc=%0d cnt=%0d expected 0 0 0",
               a_av, $signed(a_acc), a_cnt);
    end
    a_ar = 1'b1;
  endtask

  task automatic test_async_reset();
    exp_t e;
    sb_a.delete();
    a_ar = 1'b1;
    repeat (3) send_a(10);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_acc !== 16'd0 || a_cnt !== 3'd0 || a_pr !== 1'b0 || a_av !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_mid: acc=%0d cnt=%0d ready=%b valid=%b expected 0 0 0 0",
               $signed(a_acc), a_cnt, a_pr, a_av);
    end
    #2 rst_n = 1'b1;
    step();
    a_ar = 1'b0;
    repeat (4) send_a(7);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if (a_av !== 1'b0 || a_acc !== 16'd0 || a_cnt !== 3'd0 || a_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_hold: valid=%b acc=%0d cnt=%0d ovf=%b expected 0 0 0 0",
               a_av, $signed(a_acc), a_cnt, a_ovf);
    end
    #2 rst_n = 1'b1;
    a_ar = 1'b1;
    step();
    sb_a.push_back(model4(-21, -21, -21, -21, 16));
    repeat (4) send_a(-21);
    e = sb_a.pop_front();
    n_checks++;
    if (a_av !== 1'b1 || int'($signed(a_acc)) !== e.acc || a_ovf !== e.ovf) begin
      n_fail++;
      $display("FAIL arst_after: valid=%b acc=%0d ovf=%b expected 1 %0d %b",
               a_av, $signed(a_acc), a_ovf, e.acc, e.ovf);
    end
    step();
  endtask

  task automatic test_saturation();
    exp_t e;
    int sets[3][4];
    sets = '{'{64, 64, 64, 64}, '{-30, -35, -40, -50}, '{1, 1, 1, 1}};
    sb_s.delete();
    s_ar = 1'b1;
    for (int r = 0; r < 3; r++) begin
      sb_s.push_back(model4(sets[r][0], sets[r][1], sets[r][2], sets[r][3], 8));
      for (int i = 0; i < 4; i++) send_s(sets[r][i]);
      e = sb_s.pop_front();
      n_checks++;
      if (s_av !== 1'b1 || int'($signed(s_acc)) !== e.acc || s_ovf !== e.ovf || s_cnt !== 3'd4) begin
        n_fail++;
        $display("FAIL sat_result[%0d]: valid=%b acc=%0d ovf=%b cnt=%0d expected 1 %0d %b 4",
                 r, s_av, $signed(s_acc), s_ovf, s_cnt, e.acc, e.ovf);
      end
      step();
      n_checks++;
      if (s_av !== 1'b0 || s_ovf !== e.ovf) begin
        n_fail++;
        $display("FAIL sat_idle_ovf[%0d]: valid=%b ovf=%b expected 0 %b", r, s_av, s_ovf, e.ovf);
      end
    end
  endtask

  task automatic test_len1();
    exp_t e;
    sb_l.delete();
    sb_l.push_back('{acc: 21, ovf: 1'b0});
    sb_l.push_back('{acc: -30, ovf: 1'b0});
    l_ar = 1'b1;
    l_pv = 1'b1; l_pin = 8'(21);
    step();
    e = sb_l.pop_front();
    n_checks++;
    if (l_av !== 1'b1 || int'($signed(l_acc)) !== e.acc || l_pr !== 1'b0 || l_cnt !== 1'b1) begin
      n_fail++;
      $display("FAIL len1_first: valid=%b acc=%0d ready=%b cnt=%0d expected 1 %0d 0 1",
               l_av, $signed(l_acc), l_pr, l_cnt, e.acc);
    end
    l_pin = 8'(-30);
    step();
    n_checks++;
    if (l_av !== 1'b0 || l_pr !== 1'b1) begin
      n_fail++;
      $display("FAIL len1_gap: valid=%b ready=%b expected 0 1", l_av, l_pr);
    end
    step();
    e = sb_l.pop_front();
    n_checks++;
    if (l_av !== 1'b1 || int'($signed(l_acc)) !== e.acc || l_ovf !== e.ovf) begin
      n_fail++;
      $display("FAIL len1_second: valid=%b acc=%0d ovf=%b expected 1 %0d %b",
               l_av, $signed(l_acc), l_ovf, e.acc, e.ovf);
    end
    l_pv = 1'b0;
    step();
    n_checks++;
    if (l_av !== 1'b0) begin
      n_fail++;
      $display("FAIL len1_single_cycle: valid=%b expected 0", l_av);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    a_clr = 1'b0; a_pv = 1'b0; a_pin = '0; a_ar = 1'b0;
    s_clr = 1'b0; s_pv = 1'b0; s_pin = '0; s_ar = 1'b0;
    l_clr = 1'b0; l_pv = 1'b0; l_pin = '0; l_ar = 1'b0;
    #12;
    test_reset();
    #6 rst_n = 1'b1;
    step();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_clr();
    test_async_reset();
    test_saturation();
    test_len1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bm_dot_accumulator.md
Name: bm_dot_accumulator

Overview:
- Sequential stage directly downstream of the 4x4 signed Booth multiplier; consumes its signed 8-bit products.
- Accumulates LEN consecutive products into one signed dot-product result, saturating on overflow.
- Presents the result on a valid/ready output port to the next stage.
- Sits between the combinational multiplier and the result sink/register file.

Parameters:
- PROD_W, 8, width of the signed product input (matches multiplier output).
- ACC_W, 16, width of the signed accumulator and result; must be >= PROD_W.
- LEN, 4, products per result; must be >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear; aborts the current accumulation.
- prod_in  input  PROD_W  signed product from the Booth multiplier.
- prod_valid  input  1  prod_in is valid this cycle.
- prod_ready  output  1  block can accept a product this cycle.
- acc_out  output  ACC_W  signed accumulated result.
- acc_valid  output  1  acc_out holds a completed result.
- acc_ready  input  1  downstream accepts the result.
- ovf  output  1  saturation occurred during the current or held result.
- cnt  output  clog2(LEN+1)  number of products accepted into the current result.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - acc_out=0, acc_valid=0, ovf=0, cnt=0.
  - prod_ready is 0 while rst_n is low.
- Handshakes:
  - A product is accepted on a rising edge with prod_valid & prod_ready.
  - A result is consumed on a rising edge with acc_valid & acc_ready.
- prod_ready is a combinational function of state only: 1 in IDLE and ACC, 0 in HOLD. It never depends on prod_valid.
- States:
  - IDLE: on accept, acc = sign-extended prod_in, cnt=1, ovf=0. Next state is HOLD if LEN==1, otherwise ACC. With no accept, state and outputs are held.
  - ACC: on accept, acc = sat(acc + sext(prod_in)) and cnt=cnt+1. If the new cnt==LEN, go to HOLD. prod_valid low means no change (gaps are allowed and unlimited).
  - HOLD: acc_valid=1 (registered; asserted in the same edge that enters HOLD); acc_out, ovf and cnt are stable. On acc_ready, the next edge goes to IDLE with acc_valid=0 and cnt=0. acc_out keeps its last value; ovf keeps its value until the next first accept.
- Latency: the result is visible with acc_valid high in the cycle after the LEN-th product is accepted.
- Arithmetic:
  - Full-precision sum is computed at ACC_W+1 bits.
  - If the sum exceeds 2^(ACC_W-1)-1, clamp to the max and set ovf=1.
  - If the sum is below -2^(ACC_W-1), clamp to the min and set ovf=1.
  - ovf is sticky until the next result starts.
- Simultaneous events:
  - HOLD with acc_ready & prod_valid: the product is not accepted that cycle (prod_ready=0). It is accepted in IDLE on the following cycle. Throughput is one result per LEN+1 cycles minimum.
  - clr has priority over all handshakes: next state is IDLE, acc_out=0, acc_valid=0, ovf=0, cnt=0. A product presented in the clr cycle is dropped, and a held result is discarded.
  - Reset asserted mid-accumulation or in HOLD: immediate return to reset values, with no partial result emitted.
- No X propagation: prod_in is ignored when the product is not accepted.

Test Plan:
- Reset, then LEN=4 with products 21, -21, 21, 30 on consecutive cycles and acc_ready=1 -> acc_valid high for exactly 1 cycle, acc_out=51, ovf=0, cnt=4; prod_ready=0 in that cycle.
- Same four products with 1-3 idle cycles between them, then acc_ready held low for 5 cycles -> acc_out=51 stable and acc_valid=1 throughout; prod_ready=0 while held; release gives IDLE on the next edge.
- Override ACC_W=8, LEN=4, products 64, 64, 64, 64 -> acc_out=127, ovf=1. Next result -30, -35, -40, -50 -> acc_out=-128, ovf=1. A following result 1, 1, 1, 1 -> acc_out=4, ovf=0.
- After 2 products (21, 30), assert clr for 1 cycle with prod_valid=1 -> cnt=0 and acc_out=0. The clr-cycle product is dropped. A subsequent 4 products of 5 each gives acc_out=20.
- Drop rst_n asynchronously (between clock edges) after 3 products, and also separately during HOLD -> all outputs go to 0 immediately, before the next clock edge. After release, 4 products of -21 give acc_out=-84.
- LEN=1 override: products 21, -30 back-to-back with acc_ready=1 -> results 21 then -30. Each is valid for one cycle with a one-cycle IDLE gap (prod_ready low in HOLD).
